adder_pipe: RTL and testbench

Parametrised pipelined add/subtract unit, the successor to the fixed 3-bit ripple adder. It splits a WIDTH-bit carry chain into STAGE_BITS-wide segments, with one register stage per segment. It has valid/ready handshakes on both sides and produces carry-out, signed-overflow and zero flags. It is intended as a building block for the scalar/vector ALU integer datapaths.

---
 rtl/adder_pipe.sv | 140 ++++++++++++++
 tb/tb_adder_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: the carry chain is split into STAGE_BITS segments, one register
// stage each, with valid/ready on both sides. Define ADDER_PIPE_SAT_EN for the saturating mode.
module adder_pipe #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned STAGE_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
`ifdef ADDER_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NSTAGES = (WIDTH / STAGE_BITS < 1) ? 1 : WIDTH / STAGE_BITS;

    logic adv;

    // Per-stage state; a/b ride along whole, s accumulates resolved segments.
    logic [NSTAGES-1:0]            vld_q, vld_d;
    logic [NSTAGES-1:0]            c_q, c_d;
    logic [NSTAGES-1:0]            sat_q, sat_d;
    logic [NSTAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [NSTAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [NSTAGES-1:0][WIDTH-1:0] s_q, s_d;
    logic                          ovf_q, ovf_d;
    logic                          zero_q, zero_d;

    logic                  sat_in;
    logic                  v_cur, c_cur, sat_cur;
    logic [WIDTH-1:0]      a_cur, b_cur, s_cur;
    logic [STAGE_BITS:0]   seg;

`ifdef ADDER_PIPE_SAT_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    assign adv      = ~vld_q[NSTAGES-1] | out_ready;
    assign in_ready = adv;

    always_comb begin
        vld_d   = '0;
        c_d     = '0;
        sat_d   = '0;
        a_d     = '0;
        b_d     = '0;
        s_d     = '0;
        ovf_d   = 1'b0;
        zero_d  = 1'b0;
        v_cur   = 1'b0;
        c_cur   = 1'b0;
        sat_cur = 1'b0;
        a_cur   = '0;
        b_cur   = '0;
        s_cur   = '0;
        seg     = '0;
        for (int k = 0; k < NSTAGES; k++) begin
            if (k == 0) begin
                v_cur   = in_valid;
                a_cur   = in1;
                b_cur   = sub ? ~in2 : in2;
                c_cur   = sub | cin;
                sat_cur = sat_in;
                s_cur   = '0;
            end else begin
                v_cur   = vld_q[(k == 0) ? 0 : k - 1];
                a_cur   = a_q[(k == 0) ? 0 : k - 1];
                b_cur   = b_q[(k == 0) ? 0 : k - 1];
                c_cur   = c_q[(k == 0) ? 0 : k - 1];
                sat_cur = sat_q[(k == 0) ? 0 : k - 1];
                s_cur   = s_q[(k == 0) ? 0 : k - 1];
            end
            seg = {1'b0, a_cur[k*STAGE_BITS +: STAGE_BITS]}
                + {1'b0, b_cur[k*STAGE_BITS +: STAGE_BITS]}
                + {{STAGE_BITS{1'b0}}, c_cur};
            s_cur[k*STAGE_BITS +: STAGE_BITS] = seg[STAGE_BITS-1:0];
            vld_d[k] = v_cur;
            a_d[k]   = a_cur;
            b_d[k]   = b_cur;
            c_d[k]   = seg[STAGE_BITS];
            sat_d[k] = sat_cur;
            s_d[k]   = s_cur;
        end

        // Final-stage flags use the effective B, so subtraction needs no special case.
        ovf_d = (a_d[NSTAGES-1][WIDTH-1] == b_d[NSTAGES-1][WIDTH-1]) &&
                (s_d[NSTAGES-1][WIDTH-1] != a_d[NSTAGES-1][WIDTH-1]);
        if (sat_d[NSTAGES-1] && ovf_d) begin
            s_d[NSTAGES-1] = a_d[NSTAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
        zero_d = (s_d[NSTAGES-1] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            c_q    <= '0;
            sat_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            vld_q  <= vld_d;
            c_q    <= c_d;
            sat_q  <= sat_d;
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = vld_q[NSTAGES-1];
    assign sum       = s_q[NSTAGES-1];
    assign cout      = c_q[NSTAGES-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Last-stage operand copies and sat flag are dead state.
    logic unused_ok;
    assign unused_ok = ^{a_q, b_q, sat_q};

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: driver pushes model results on acceptance, monitor pops them
// when the DUT hands a result over. A second 8-bit instance covers the single-stage build.
module tb_adder_pipe;

    localparam int unsigned NST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, sat;
    logic [31:0] in1, in2, sum;
    logic        out_valid, out_ready, cout, ovf, zero;

    logic        in_valid8, in_ready8, cin8, sub8, sat8;
    logic [7:0]  in1_8, in2_8, sum8;
    logic        out_valid8, cout8, ovf8, zero8;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(32), .STAGE_BITS(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .cin(cin), .sub(sub),
`ifdef ADDER_PIPE_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    adder_pipe #(.WIDTH(8), .STAGE_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .in1(in1_8), .in2(in2_8), .cin(cin8), .sub(sub8),
`ifdef ADDER_PIPE_SAT_EN
        .sat(sat8),
`endif
        .out_valid(out_valid8), .out_ready(1'b1),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    typedef struct {
        logic [31:0] sum;
        logic [2:0]  flg;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sbq[$];
    exp_t        ent;
    int          tests = 0;
    int          fails = 0;
    int          ncyc  = 0;
    bit          held_v = 1'b0;
    bit          done = 1'b0;
    logic [31:0] h_sum;
    logic [2:0]  h_flg;
    logic [31:0] ra, rb;

    always @(posedge clk) ncyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at t=%0t", name, act, want, $time);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the full operands.
    function automatic exp_t model(input logic [31:0] a, b, input logic c, s, st);
        exp_t        e;
        longint      sa, sb, r;
        logic [32:0] u;
        logic        co, ov, z;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = s ? sa - sb : sa + sb + longint'(c);
        u  = {1'b0, a} + {1'b0, b} + {32'd0, c};
        co = s ? (a >= b) : u[32];
        ov = (r > longint'(32'h7FFF_FFFF)) || (r < -longint'(32'h8000_0000));
        e.sum = r[31:0];
        if (st && ov) e.sum = (sa >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        z = (e.sum == 32'd0);
        e.flg = {co, ov, z};
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    // Call #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] a, b, input logic c, s, st, input bit lat);
        exp_t e;
        bit   acc;
        in1 = a;
        in2 = b;
        cin = c;
        sub = s;
`ifdef ADDER_PIPE_SAT_EN
        sat = st;
        e = model(a, b, c, s, st);
`else
        sat = st;
        e = model(a, b, c, s, 1'b0);
`endif
        in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                e.acc = ncyc;
                e.lat = lat;
                sbq.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sbq.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", sbq.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            held_v = 1'b0;
        end else begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (held_v) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_sum", sum, h_sum);
                chk("hold_flags", {29'd0, cout, ovf, zero}, {29'd0, h_flg});
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", {31'd0, out_valid}, 32'd0);
                end else begin
                    ent = sbq.pop_front();
                    chk("sum", sum, ent.sum);
                    chk("cout_ovf_zero", {29'd0, cout, ovf, zero}, {29'd0, ent.flg});
                    if (ent.lat) chk("latency", ncyc - ent.acc, NST);
                end
            end
            held_v = out_valid && !out_ready;
            h_sum  = sum;
            h_flg  = {cout, ovf, zero};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
        in_valid8 = 1'b0; in1_8 = '0; in2_8 = '0; cin8 = 1'b0; sub8 = 1'b0; sat8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid8", {31'd0, out_valid8}, 32'd0);
        @(posedge clk);
        #1;

        // Directed corner cases, no stalls so latency is checked.
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b1);
        issue(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();

        // Back-to-back stream with a 4-cycle output stall once the pipe is full.
        fork
            begin
                for (int i = 0; i < 6; i++) issue(32'(i), 32'(i) * 32'h0101_0101, 1'b0, 1'b0,
                                                  1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-flight, with a transfer presented in the reset cycle.
        issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(32'h3333_3333, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
        in1 = 32'h5555_5555; in2 = 32'h1; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("rst_quiet", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        issue(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();

        // Random operands with random back-pressure.
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    case ($urandom_range(0, 3))
                        0:       ra = 32'h7FFF_FFFF;
                        1:       ra = 32'h8000_0000;
                        2:       ra = 32'hFFFF_FFFF;
                        default: ra = $urandom;
                    endcase
                    rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
                    issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'b0);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                for (int t = 0; t < 5000 && !done; t++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Single-stage build: latency 1.
        in1_8 = 8'h80; in2_8 = 8'h80; in_valid8 = 1'b1;
        @(negedge clk);
        chk("d8_in_ready", {31'd0, in_ready8}, 32'd1);
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        @(negedge clk);
        chk("d8_out_valid", {31'd0, out_valid8}, 32'd1);
        chk("d8_sum", {24'd0, sum8}, 32'd0);
        chk("d8_flags", {29'd0, cout8, ovf8, zero8}, 32'd7);
        @(negedge clk);
        chk("d8_out_valid_drop", {31'd0, out_valid8}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
